// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: FSM encoding, port ids, MemOp width.
package dmem_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_LD  = 1'b1;

  localparam int MEMOP_W = 3;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: a sole requester wins, a tie goes to the port that did not win last.
module rr_arb2
  import dmem_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       win_id,
  output logic       any_req
);

  // Winner selection
  always_comb begin
    any_req = |req;
    if (req == 2'b11) begin
      win_id = (last == PORT_CPU) ? PORT_LD : PORT_CPU;
    end else begin
      win_id = req[PORT_LD] ? PORT_LD : PORT_CPU;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one data-memory port between the CPU (port 0) and the loader/debug path (port 1),
// running one fixed-latency access at a time and returning a registered one-cycle done pulse.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int READ_LAT = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               p0_req,
  input  logic               p0_we,
  input  logic [AW-1:0]      p0_addr,
  input  logic [DW-1:0]      p0_wdata,
  input  logic [MEMOP_W-1:0] p0_memop,
  input  logic               p1_req,
  input  logic               p1_we,
  input  logic [AW-1:0]      p1_addr,
  input  logic [DW-1:0]      p1_wdata,
  input  logic [MEMOP_W-1:0] p1_memop,
  output logic               p0_done,
  output logic               p1_done,
  output logic [DW-1:0]      rdata,
  output logic               cpu_stall,
  output logic               mem_en,
  output logic               mem_we,
  output logic [AW-1:0]      mem_addr,
  output logic [DW-1:0]      mem_wdata,
  output logic [MEMOP_W-1:0] mem_op,
  input  logic [DW-1:0]      mem_rdata
);

  localparam int              CNT_W    = $clog2(READ_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(READ_LAT);

  state_e               state_q, state_d;
  logic                 win_q, win_d;
  logic                 we_q, we_d;
  logic [AW-1:0]        addr_q, addr_d;
  logic [DW-1:0]        wdata_q, wdata_d;
  logic [MEMOP_W-1:0]   op_q, op_d;
  logic                 last_q, last_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 p0_done_q, p0_done_d;
  logic                 p1_done_q, p1_done_d;
  logic [DW-1:0]        rdata_q, rdata_d;

  logic [1:0]           req_eff;
  logic                 win_id;
  logic                 any_req;

  // A port whose done is showing this cycle is still holding req; don't re-grant it.
  assign req_eff = {p1_req & ~p1_done_q, p0_req & ~p0_done_q};

  rr_arb2 u_arb (
    .req     (req_eff),
    .last    (last_q),
    .win_id  (win_id),
    .any_req (any_req)
  );

  // Next-state, request latching, latency counter and done generation
  always_comb begin
    state_d   = state_q;
    win_d     = win_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    op_d      = op_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    rdata_d   = rdata_q;
    p0_done_d = 1'b0;
    p1_done_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_d = {CNT_W{1'b0}};
        if (any_req) begin
          win_d   = win_id;
          last_d  = win_id;
          state_d = ST_BUSY;
          if (win_id == PORT_LD) begin
            we_d    = p1_we;
            addr_d  = p1_addr;
            wdata_d = p1_wdata;
            op_d    = p1_memop;
          end else begin
            we_d    = p0_we;
            addr_d  = p0_addr;
            wdata_d = p0_wdata;
            op_d    = p0_memop;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (we_q || (cnt_q == CNT_LAST)) begin
          state_d   = ST_IDLE;
          cnt_d     = {CNT_W{1'b0}};
          p0_done_d = (win_q == PORT_CPU);
          p1_done_d = (win_q == PORT_LD);
          if (!we_q) begin
            rdata_d = mem_rdata;
          end else begin
            rdata_d = rdata_q;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = {CNT_W{1'b0}};
      end
    endcase
  end

  // State registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      win_q     <= PORT_CPU;
      we_q      <= 1'b0;
      addr_q    <= {AW{1'b0}};
      wdata_q   <= {DW{1'b0}};
      op_q      <= {MEMOP_W{1'b0}};
      last_q    <= PORT_LD;
      cnt_q     <= {CNT_W{1'b0}};
      p0_done_q <= 1'b0;
      p1_done_q <= 1'b0;
      rdata_q   <= {DW{1'b0}};
    end else begin
      state_q   <= state_d;
      win_q     <= win_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      op_q      <= op_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      p0_done_q <= p0_done_d;
      p1_done_q <= p1_done_d;
      rdata_q   <= rdata_d;
    end
  end

  // Memory-side drive, decoded from registered state so reset drops it immediately
  always_comb begin
    if (state_q == ST_BUSY) begin
      mem_en    = 1'b1;
      mem_we    = we_q;
      mem_addr  = addr_q;
      mem_wdata = wdata_q;
      mem_op    = op_q;
    end else begin
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = {AW{1'b0}};
      mem_wdata = {DW{1'b0}};
      mem_op    = {MEMOP_W{1'b0}};
    end
  end

  assign p0_done   = p0_done_q;
  assign p1_done   = p1_done_q;
  assign rdata     = rdata_q;
  assign cpu_stall = p0_req & ~p0_done_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter (READ_LAT=3) with a behavioural memory and a done scoreboard.
module tb_dmem_arbiter;
  import dmem_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int RL = 3;

  logic               clk = 1'b0;
  logic               reset;
  logic               p0_req, p0_we, p1_req, p1_we;
  logic [AW-1:0]      p0_addr, p1_addr;
  logic [DW-1:0]      p0_wdata, p1_wdata;
  logic [MEMOP_W-1:0] p0_memop, p1_memop;
  logic               p0_done, p1_done, cpu_stall, mem_en, mem_we;
  logic [DW-1:0]      rdata, mem_wdata, mem_rdata;
  logic [AW-1:0]      mem_addr;
  logic [MEMOP_W-1:0] mem_op;

  always #5 clk = ~clk;

  dmem_arbiter #(.AW(AW), .DW(DW), .READ_LAT(RL)) dut (
    .clk(clk), .reset(reset),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_memop(p0_memop),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_memop(p1_memop),
    .p0_done(p0_done), .p1_done(p1_done), .rdata(rdata), .cpu_stall(cpu_stall),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_op(mem_op), .mem_rdata(mem_rdata)
  );

  // Memory model: synchronous write, read data appears RL clocks after the address
  logic [DW-1:0] mem  [0:63];
  logic [DW-1:0] pipe [0:RL-1];
  assign mem_rdata = pipe[RL-1];
  always @(posedge clk) begin
    if (mem_en && mem_we) mem[mem_addr[7:2]] <= mem_wdata;
    pipe[0] <= (mem_en && !mem_we) ? mem[mem_addr[7:2]] : 32'h0;
    for (int i = 1; i < RL; i++) pipe[i] <= pipe[i-1];
  end

  typedef struct {
    logic          port;
    logic          is_load;
    logic [DW-1:0] rdata;
  } exp_t;

  typedef struct {
    logic               port;
    logic               we;
    logic [AW-1:0]      addr;
    logic [DW-1:0]      wdata;
    logic [MEMOP_W-1:0] op;
    logic [DW-1:0]      exp_rdata;
    int                 exp_lat;
  } vec_t;

  exp_t          sbq[$];
  vec_t          vecs[8];
  int            n_tests = 0;
  int            n_fail  = 0;
  logic [DW-1:0] last_load = 32'h0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    p0_req = 1'b0; p0_we = 1'b0; p0_addr = 32'h0; p0_wdata = 32'h0; p0_memop = 3'd0;
    p1_req = 1'b0; p1_we = 1'b0; p1_addr = 32'h0; p1_wdata = 32'h0; p1_memop = 3'd0;
  endtask

  task automatic drive_port(input logic port, input logic we, input logic [AW-1:0] addr,
                            input logic [DW-1:0] wdata, input logic [MEMOP_W-1:0] op);
    if (port) begin
      p1_req = 1'b1; p1_we = we; p1_addr = addr; p1_wdata = wdata; p1_memop = op;
    end else begin
      p0_req = 1'b1; p0_we = we; p0_addr = addr; p0_wdata = wdata; p0_memop = op;
    end
  endtask

  // One isolated transaction from a vector: latency, strobe, passthrough and read data
  task automatic run_txn(input vec_t v);
    exp_t e;
    int   n;
    int   we_cycles;
    bit   seen;
    @(negedge clk);
    drive_port(v.port, v.we, v.addr, v.wdata, v.op);
    e.port = v.port; e.is_load = !v.we; e.rdata = v.exp_rdata;
    sbq.push_back(e);
    n = 0; we_cycles = 0; seen = 1'b0;
    while (!seen && n < 20) begin
      @(negedge clk);
      n++;
      if (mem_we) begin
        we_cycles++;
        check("st_addr", mem_addr, v.addr);
        check("st_wdata", mem_wdata, v.wdata);
      end
      if (mem_en) check("mem_op", mem_op, v.op);
      if (v.port && !p1_done) check("p0_quiet", p0_done, 1'b0);
      if (p0_done || p1_done) seen = 1'b1;
    end
    if (!seen) begin
      check("done_timeout", 1'b0, 1'b1);
      void'(sbq.pop_front());
    end else begin
      e = sbq.pop_front();
      check("done_port", {p1_done, p0_done}, e.port ? 2'b10 : 2'b01);
      check("latency", n, v.exp_lat);
      check("we_cycles", we_cycles, v.we ? 1 : 0);
      if (!e.port) check("stall_in_done", cpu_stall, 1'b0);
      if (e.is_load) begin
        check("load_rdata", rdata, e.rdata);
        last_load = e.rdata;
      end else begin
        check("rdata_hold", rdata, last_load);
      end
    end
    idle_inputs();
  endtask

  initial begin
    exp_t e;
    reset = 1'b1;
    idle_inputs();

    vecs[0] = '{1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 3'd2, 32'h0,        2};
    vecs[1] = '{1'b0, 1'b0, 32'h10, 32'h0,        3'd2, 32'hDEADBEEF, RL + 2};
    vecs[2] = '{1'b1, 1'b1, 32'h20, 32'h12345678, 3'd2, 32'h0,        2};
    vecs[3] = '{1'b1, 1'b0, 32'h20, 32'h0,        3'd4, 32'h12345678, RL + 2};
    vecs[4] = '{1'b0, 1'b0, 32'h04, 32'h0,        3'd1, 32'h00000A0A, RL + 2};
    vecs[5] = '{1'b1, 1'b1, 32'h10, 32'hCAFEF00D, 3'd0, 32'h0,        2};
    vecs[6] = '{1'b0, 1'b0, 32'h10, 32'h0,        3'd5, 32'hCAFEF00D, RL + 2};
    vecs[7] = '{1'b0, 1'b1, 32'h08, 32'hA5A5A5A5, 3'd1, 32'h0,        2};

    // Reset held with both ports requesting stores
    drive_port(1'b0, 1'b1, 32'h04, 32'h00000A0A, 3'd2);
    drive_port(1'b1, 1'b1, 32'h08, 32'h00000B0B, 3'd2);
    repeat (3) @(negedge clk);
    check("rst_mem_en", mem_en, 1'b0);
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_mem_op", mem_op, 3'd0);
    check("rst_done", {p1_done, p0_done}, 2'b00);
    check("rst_rdata", rdata, 32'h0);
    check("rst_stall", cpu_stall, 1'b1);

    for (int k = 0; k < 4; k++) begin
      e.port = k[0]; e.is_load = 1'b0; e.rdata = 32'h0;
      sbq.push_back(e);
    end
    reset = 1'b0;
    // Both held: p0 first, then strict alternation, done every second cycle
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 1) begin
        check("first_grant_en", mem_en, 1'b1);
        check("first_grant_addr", mem_addr, 32'h04);
      end
      check("alt_p0_done", p0_done, (c == 2 || c == 6));
      check("alt_p1_done", p1_done, (c == 4 || c == 8));
      check("alt_stall", cpu_stall, !(c == 2 || c == 6));
      if (p0_done || p1_done) begin
        if (sbq.size() == 0) begin
          check("alt_sb_underflow", 1'b1, 1'b0);
        end else begin
          e = sbq.pop_front();
          check("alt_order", {p1_done, p0_done}, e.port ? 2'b10 : 2'b01);
        end
      end
    end
    idle_inputs();
    check("alt_sb_empty", sbq.size(), 0);

    // Isolated transactions, one idle cycle in front of each
    for (int i = 0; i < 8; i++) run_txn(vecs[i]);

    // p1 load drops its request mid-access while p0 starts waiting
    @(negedge clk);
    drive_port(1'b1, 1'b0, 32'h20, 32'h0, 3'd4);
    e.port = 1'b1; e.is_load = 1'b1; e.rdata = 32'h12345678;
    sbq.push_back(e);
    @(negedge clk);
    p1_req = 1'b0;
    drive_port(1'b0, 1'b1, 32'h30, 32'h00000055, 3'd2);
    e.port = 1'b0; e.is_load = 1'b0; e.rdata = 32'h12345678;
    sbq.push_back(e);
    for (int c = 2; c <= 8; c++) begin
      @(negedge clk);
      check("drop_p1_done", p1_done, (c == 5));
      check("drop_p0_done", p0_done, (c == 7));
      if (c == 6) begin
        check("drop_p0_grant_we", mem_we, 1'b1);
        check("drop_p0_grant_addr", mem_addr, 32'h30);
      end
      if (p0_done || p1_done) begin
        if (sbq.size() == 0) begin
          check("drop_sb_underflow", 1'b1, 1'b0);
        end else begin
          e = sbq.pop_front();
          check("drop_port", {p1_done, p0_done}, e.port ? 2'b10 : 2'b01);
          if (e.is_load) check("drop_rdata", rdata, e.rdata);
        end
      end
      if (c == 7) p0_req = 1'b0;
    end
    idle_inputs();
    check("drop_sb_empty", sbq.size(), 0);
    last_load = 32'h12345678;

    // Reset in the second BUSY cycle of a load aborts without a done
    @(negedge clk);
    drive_port(1'b0, 1'b0, 32'h10, 32'h0, 3'd2);
    @(negedge clk);
    @(negedge clk);
    check("abort_busy_before", mem_en, 1'b1);
    reset = 1'b1;
    #1;
    check("abort_mem_en", mem_en, 1'b0);
    check("abort_mem_we", mem_we, 1'b0);
    check("abort_mem_addr", mem_addr, 32'h0);
    idle_inputs();
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c == 2) reset = 1'b0;
      check("abort_no_done", {p1_done, p0_done}, 2'b00);
      check("abort_idle", mem_en, 1'b0);
    end
    last_load = 32'h0;
    run_txn(vecs[2]);
    check("final_sb_empty", sbq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
